// File: rtl/fir31_lpf_12k.sv
// 31-tap symmetric low-pass FIR (48 kHz, 12 kHz cutoff) for the audio effects chain.
// One time-multiplexed MAC per sample; saturated 18-bit result strobed with done.
module fir31_lpf_12k #(
  parameter int unsigned NTAPS = 31,
  parameter int unsigned ACC_W = 20
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic signed [7:0]  x,
  output logic signed [17:0] y,
  output logic               done
);

  localparam int unsigned X_W   = 8;
  localparam int unsigned C_W   = 11;
  localparam int unsigned P_W   = X_W + C_W;
  localparam int unsigned Y_W   = 18;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned PTR_W = 5;

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32'sd131071);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-32'sd131072);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic        [PTR_W-1:0] ptr;
  logic        [PTR_W-1:0] k;
  logic signed [X_W-1:0]   hist [DEPTH];
  logic signed [ACC_W-1:0] acc;

  logic        [PTR_W-1:0] tap_idx_c;
  logic signed [C_W-1:0]   coef_c;
  logic signed [X_W-1:0]   samp_c;
  logic signed [P_W-1:0]   prod_c;
  logic signed [Y_W-1:0]   y_sat_c;
  logic                    last_tap_c;

  // Half-table coefficient ROM; taps 16..30 fold back onto 14..0.
  function automatic logic signed [C_W-1:0] coef_rom(input logic [PTR_W-1:0] idx);
    logic [PTR_W-1:0] m;
    m = (idx > 5'd15) ? PTR_W'(5'd30 - idx) : idx;
    case (m)
      5'd0:    coef_rom = -11'sd2;
      5'd2:    coef_rom =  11'sd3;
      5'd4:    coef_rom = -11'sd7;
      5'd6:    coef_rom =  11'sd14;
      5'd8:    coef_rom = -11'sd27;
      5'd10:   coef_rom =  11'sd50;
      5'd12:   coef_rom = -11'sd99;
      5'd14:   coef_rom =  11'sd323;
      5'd15:   coef_rom =  11'sd514;
      default: coef_rom =  11'sd0;
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MAC;
      MAC:     if (last_tap_c) state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Tap fetch, product and output saturation
  always_comb begin
    tap_idx_c  = PTR_W'(ptr - k);
    coef_c     = coef_rom(k);
    samp_c     = hist[tap_idx_c];
    prod_c     = P_W'(coef_c) * P_W'(samp_c);
    last_tap_c = (k == PTR_W'(NTAPS - 1));
    if (acc > SAT_HI)      y_sat_c = SAT_HI[Y_W-1:0];
    else if (acc < SAT_LO) y_sat_c = SAT_LO[Y_W-1:0];
    else                   y_sat_c = acc[Y_W-1:0];
  end

  // Sample history, accumulator and registered outputs; pointer advances only after a result.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) hist[i] <= '0;
      ptr  <= '0;
      k    <= '0;
      acc  <= '0;
      y    <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            hist[ptr] <= x;
            acc       <= '0;
            k         <= '0;
          end
        end
        MAC: begin
          acc <= acc + ACC_W'(prod_c);
          k   <= PTR_W'(k + 5'd1);
        end
        OUT: begin
          y    <= y_sat_c;
          done <= 1'b1;
          ptr  <= PTR_W'(ptr + 5'd1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir31_lpf_12k.sv
// Bench for fir31_lpf_12k: randomized and directed samples checked against a
// convolution model holding the most recent 31 inputs.
module tb_fir31_lpf_12k;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic signed [7:0]  x     = '0;
  logic signed [17:0] y;
  logic               done;

  int checks   = 0;
  int failures = 0;

  int coef [31] = '{-2, 0, 3, 0, -7, 0, 14, 0, -27, 0, 50, 0, -99, 0, 323,
                    514, 323, 0, -99, 0, 50, 0, -27, 0, 14, 0, -7, 0, 3, 0, -2};
  int hist [31];
  int model_y = 0;

  fir31_lpf_12k dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .x     (x),
    .y     (y),
    .done  (done)
  );

  always #5 clock = ~clock;

  function automatic int sat18(input int v);
    if (v > 131071)  return 131071;
    if (v < -131072) return -131072;
    return v;
  endfunction

  function automatic int sgn(input int v);
    return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 31; i++) hist[i] = 0;
    model_y = 0;
  endtask

  // Push a sample into the model history and return the filter output for it.
  task automatic model_push(input int s, output int exp_y);
    int acc;
    for (int i = 30; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = s;
    acc = 0;
    for (int i = 0; i < 31; i++) acc += coef[i] * hist[i];
    exp_y = sat18(acc);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    model_clear();
  endtask

  // Issue one sample; optionally pulse an extra start at edge extra_at (relative to the sampling edge).
  task automatic send(input int s, input int extra_at, input string tag);
    int exp_y, prev_y, cnt, pos;
    prev_y = model_y;
    model_push(s, exp_y);
    @(negedge clock);
    start = 1'b1;
    x     = 8'(s);
    @(posedge clock);
    #1;
    start = (extra_at == 1);
    x     = 8'($urandom);
    cnt = 0;
    pos = -1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clock);
      #1;
      if (done === 1'b1) begin
        cnt++;
        pos = e;
      end
      if (e == 31) begin
        checks++;
        if (int'(y) !== prev_y) begin
          failures++;
          $display("FAIL %s y_before_done got=%0d want=%0d", tag, int'(y), prev_y);
        end
      end
      start = (e + 1 == extra_at);
      x     = 8'($urandom);
    end
    start = 1'b0;
    checks++;
    if (cnt !== 1 || pos !== 32) begin
      failures++;
      $display("FAIL %s done_timing pulses=%0d at_edge=%0d want 1 at 32", tag, cnt, pos);
    end
    checks++;
    if (int'(y) !== exp_y) begin
      failures++;
      $display("FAIL %s y got=%0d want=%0d", tag, int'(y), exp_y);
    end
    model_y = exp_y;
    repeat (23) @(posedge clock);
  endtask

  task automatic expect_y(input int want, input string tag);
    checks++;
    if (int'(y) !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", tag, int'(y), want);
    end
  endtask

  task automatic expect_quiet(input string tag);
    int cnt;
    cnt = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clock);
      #1;
      if (done !== 1'b0) cnt++;
    end
    checks++;
    if (cnt !== 0) begin
      failures++;
      $display("FAIL %s stray_done cycles=%0d want=0", tag, cnt);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (y !== 18'sd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state y=%0d done=%b want 0/0", int'(y), done);
    end
  endtask

  task automatic test_impulse(input string tag);
    send(100, 0, tag);
    expect_y(-200, {tag, "_first"});
    for (int i = 1; i < 32; i++) begin
      send(0, 0, tag);
      if (i == 15) expect_y(51400, {tag, "_center"});
    end
    expect_y(0, {tag, "_tail"});
  endtask

  task automatic test_dc();
    do_reset();
    for (int i = 0; i < 31; i++) send(1, 0, "dc1");
    expect_y(1024, "dc1_settled");
    for (int i = 0; i < 31; i++) send(127, 0, "dc127");
    expect_y(130048, "dc127_settled");
    for (int i = 0; i < 31; i++) send(-128, 0, "dcm128");
    expect_y(-131072, "dcm128_settled");
  endtask

  task automatic test_nyquist();
    do_reset();
    for (int i = 0; i < 36; i++) send((i % 2 == 0) ? 127 : -127, 0, "nyq");
    checks++;
    if (int'(y) !== 508 && int'(y) !== -508) begin
      failures++;
      $display("FAIL nyq_settled got=%0d want=+-508", int'(y));
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int j = 30; j >= 0; j--) send(127 * sgn(coef[j]), 0, "sat_pos");
    expect_y(131071, "sat_pos_final");
    for (int j = 30; j >= 0; j--) send(-127 * sgn(coef[j]), 0, "sat_neg");
    expect_y(-131072, "sat_neg_final");
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 40; i++) send($signed(8'($urandom)), 0, "rand");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) send($signed(8'($urandom)), 10, "ignore_mac");
    for (int i = 0; i < 4; i++) send($signed(8'($urandom)), 32, "ignore_out");
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    start = 1'b1;
    x     = 8'sd55;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (15) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    model_clear();
    expect_y(0, "midreset_y");
    expect_quiet("midreset");
    test_impulse("post_reset_imp");
  endtask

  task automatic test_reset_with_start();
    send(90, 0, "pre_rs");
    @(negedge clock);
    reset = 1'b1;
    start = 1'b1;
    x     = 8'sd77;
    @(posedge clock);
    #1;
    reset = 1'b0;
    start = 1'b0;
    model_clear();
    expect_quiet("reset_with_start");
    send(0, 0, "after_rs");
    expect_y(0, "after_rs_zero_hist");
  endtask

  initial begin
    test_reset();
    test_impulse("impulse");
    test_dc();
    test_nyquist();
    test_saturation();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_reset_with_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir31_lpf_12k.md
Name: fir31_lpf_12k

Overview:
- 31-tap symmetric low-pass FIR filter for the audio effects chain.
- Nominal 48 kHz sample rate with a 12 kHz cutoff (Hamming-windowed, 0.5·Nyquist).
- One signed 8-bit sample is accepted per `start` pulse.
- Each result is computed with a single time-multiplexed multiply-accumulate over 31 taps and reported as an 18-bit signed value with a `done` strobe.
- The upstream sample source issues `start` no more often than every 64 clocks.

Parameters:
- NTAPS, 31, number of taps (fixed; the coefficient ROM is sized for 31).
- ACC_W, 20, internal accumulator width in bits.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse: `x` is a new sample.
- x  input  8  signed two's-complement input sample, valid when `start`=1.
- y  output  18  signed filtered output; held between updates.
- done  output  1  one-cycle pulse when `y` has just been updated.

Behaviour:
- Coefficients c[0..30], signed 11-bit, DC gain 1024:
  - c[0..14] = -2,0,3,0,-7,0,14,0,-27,0,50,0,-99,0,323
  - c[15] = 514
  - c[16..30] mirror c[14..0] (c[30-k] = c[k]).
  - Sum of all coefficients = 1024.
- y[n] = Σ_{k=0..30} c[k]·x[n-k], where x[n] is the sample taken with the current `start`.
- History: 32-entry circular sample buffer with a 5-bit write pointer that wraps 31→0.
- Reset: `y`=0, `done`=0, all 32 buffer entries=0, pointer=0, FSM=IDLE.
- IDLE: on a clock edge with `start`=1:
  - write `x` at the pointer, clear the accumulator, set tap index k=0, go to MAC.
- MAC: one tap per clock.
  - acc += c[k]·buf[pointer-k mod 32], with sign extension to ACC_W.
  - After k=30 (31 MAC cycles), go to OUT.
- OUT (one cycle):
  - `y` ← acc saturated to the 18-bit range [-131072, +131071].
  - `done`=1 for exactly this cycle.
  - Pointer increments (wrap 31→0).
  - Return to IDLE.
- Latency: `done` is high on the 33rd rising edge after the edge that sampled `start`. The new `y` is visible together with `done` and is held until the next OUT.
- `start` while in MAC or OUT is ignored: no sample is written and the computation in progress is not disturbed.
- `start` in the same cycle as `reset`: reset wins.
- Reset mid-computation aborts it. `done` does not pulse, and the buffer is cleared.
- Samples preceding reset are treated as 0, so the first 30 outputs after reset reflect zero history.
- `x` is only sampled on the `start` edge; `x` may change at any other time.

Test Plan:
- Impulse: reset, then one sample x=100 followed by zeros, one `start` every 64 clocks.
  - Successive `y` values are 100·c[k]: -200, 0, 300, 0, -700, …, 32300, 51400, 32300, …, -200, then 0.
- DC: constant x=1.
  - From the 31st sample on, y=1024.
  - Constant x=127 gives y=130048; constant x=-128 gives y=-131072 (no saturation).
- Nyquist: alternating x=+127/-127.
  - Settled output is ±508 (gain -4/1024), showing stop-band attenuation.
- Saturation: history x[n-k]=127·sign(c[k]), zeros where c[k]=0.
  - Ideal 198628 gives y=131071; the negated pattern gives y=-131072.
- Timing/handshake:
  - `done` is high exactly one cycle, 33 edges after `start`.
  - A second `start` 10 cycles after the first is ignored: next `y` unchanged versus a bench without it.
  - Reset asserted at MAC cycle 15 gives no `done`, y=0, and a subsequent impulse reproduces the impulse-test sequence.
